// File: rtl/i2s_capture_if.sv
// i2s_capture_if: valid/ready word stream from the I2S capture stage to the driver FIFO
interface i2s_capture_if #(
  parameter int DATA_SIZE = 28
);
  logic                 source_valid;
  logic [DATA_SIZE-1:0] source_data;
  logic [1:0]           source_ready;
  modport master (output source_valid, source_data, input source_ready);
  modport slave (input source_valid, source_data, output source_ready);
endinterface

// File: rtl/i2s_capture.sv
// i2s_capture: oversampled I2S deserialiser emitting tagged {chan, seq, sample} words
// through a one-deep valid/ready register, with sticky overflow and short-slot flags.
module i2s_capture #(
  parameter int SAMPLE_BITS = 24,
  parameter int DATA_SIZE = SAMPLE_BITS + 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2s_bclk,
  input  logic          i2s_lrclk,
  input  logic          i2s_sdata,
  input  logic          enable,
  input  logic          flags_clr,
  i2s_capture_if.master src,
  output logic          overflow,
  output logic          short_frame
);
  localparam int CW = $clog2(SAMPLE_BITS + 1);
  typedef enum logic [1:0] {IDLE, ARM, HUNT, SHIFT} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] bclk_s, lr_s, sd_s;
  logic                   bclk_prev, lr_prev, chan;
  logic [2:0]             seq;
  logic [CW-1:0]          bitcnt;
  logic [SAMPLE_BITS-2:0] shreg;
  logic                   rise, lr, sd, take, last_bit;
  logic [SAMPLE_BITS-1:0] sample;
  assign rise     = bclk_s[SYNC_STAGES-1] & ~bclk_prev;
  assign lr       = lr_s[SYNC_STAGES-1];
  assign sd       = sd_s[SYNC_STAGES-1];
  assign sample   = {shreg, sd};
  assign take     = !src.source_valid || src.source_ready[0];
  assign last_bit = bitcnt == CW'(SAMPLE_BITS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bclk_s           <= '0;
      lr_s             <= '0;
      sd_s             <= '0;
      bclk_prev        <= 1'b0;
      lr_prev          <= 1'b0;
      chan             <= 1'b0;
      seq              <= '0;
      bitcnt           <= '0;
      shreg            <= '0;
      state            <= IDLE;
      src.source_valid <= 1'b0;
      src.source_data  <= '0;
      overflow         <= 1'b0;
      short_frame      <= 1'b0;
    end else begin
      bclk_s    <= {bclk_s[SYNC_STAGES-2:0], i2s_bclk};
      lr_s      <= {lr_s[SYNC_STAGES-2:0], i2s_lrclk};
      sd_s      <= {sd_s[SYNC_STAGES-2:0], i2s_sdata};
      bclk_prev <= bclk_s[SYNC_STAGES-1];
      if (src.source_valid && src.source_ready[0]) src.source_valid <= 1'b0;
      // clears come first so a same-cycle set below wins
      if (flags_clr) begin
        overflow    <= 1'b0;
        short_frame <= 1'b0;
      end
      if (!enable) state <= IDLE;
      else case (state)
        IDLE: state <= ARM;
        ARM: if (rise) begin
          lr_prev <= lr;
          state   <= HUNT;
        end
        HUNT: if (rise) begin
          lr_prev <= lr;
          if (lr != lr_prev) begin
            chan   <= lr;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: if (rise) begin
          lr_prev <= lr;
          if (lr != lr_prev) begin
            short_frame <= 1'b1;
            chan        <= lr;
            bitcnt      <= '0;
          end else begin
            shreg  <= sample[SAMPLE_BITS-2:0];
            bitcnt <= bitcnt + 1'b1;
            if (last_bit) begin
              state <= HUNT;
              seq   <= chan ? seq + 3'd1 : seq;
              if (take) begin
                src.source_valid <= 1'b1;
                src.source_data  <= DATA_SIZE'({chan, seq, sample});
              end else overflow <= 1'b1;
            end
          end
        end
      endcase
    end
endmodule
